// File: rtl/d_input_debounce_if.sv
// Signal bundle between a raw external level source and the debouncer.
// The master drives raw_in; the debouncer (slave) returns the conditioned level and strobes.
interface d_input_debounce_if;
  logic raw_in;
  logic d_out;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output raw_in,
    input  d_out,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  raw_in,
    output d_out,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/d_input_debounce.sv
// Two-flop synchronizer plus stability-qualified level change for slow external inputs.
// d_out only follows the synchronized level after it has held for STABLE_CYCLES+1 samples.
module d_input_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                clear_n,
  d_input_debounce_if.slave   dbus
);

  typedef enum logic {StStable, StCheck} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_d_out;
  logic             r_rise;
  logic             r_fall;
  logic             w_differs;
  logic             w_commit;

  // raw_in is only ever sampled here; nothing downstream sees it directly.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= dbus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = (r_sync2 != r_d_out);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= StStable;
      r_cnt   <= '0;
      r_d_out <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_commit ? r_sync2 : r_d_out;
      // A commit only happens when sync2 differs from d_out, so sync2 gives the direction.
      r_rise  <= w_commit & r_sync2;
      r_fall  <= w_commit & ~r_sync2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_commit    = 1'b0;
    unique case (r_state)
      StStable: begin
        if (w_differs) begin
          w_state_nxt = StCheck;
        end
      end
      StCheck: begin
        if (!w_differs) begin
          w_state_nxt = StStable;
        end else if (r_cnt == LastCnt) begin
          w_commit    = 1'b1;
          w_state_nxt = StStable;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StStable;
    endcase
  end

  always_comb begin
    dbus.d_out = r_d_out;
    dbus.rise  = r_rise;
    dbus.fall  = r_fall;
    dbus.busy  = (r_state == StCheck);
  end

endmodule

// File: tb/tb_d_input_debounce.sv
// Directed bench: default-parameter debouncer driven from a vector table plus hand sequences,
// and a STABLE_CYCLES=2 instance for the short-qualification corner.
module tb_d_input_debounce;

  typedef struct {
    string       name;
    bit          clr;
    bit          raw;
    int          edges;
    logic [3:0]  exp;   // {d_out, rise, fall, busy}
  } vec_t;

  logic clk;
  logic clear_n;
  int   vectors;
  int   miscompares;
  int   rise_a, fall_a, rise_b, fall_b;
  vec_t vecs[$];

  d_input_debounce_if if_a ();
  d_input_debounce_if if_b ();

  d_input_debounce #(
    .STABLE_CYCLES (16),
    .CNT_W         (8),
    .RESET_VAL     (1'b0)
  ) u_dut_a (
    .clk     (clk),
    .clear_n (clear_n),
    .dbus    (if_a)
  );

  d_input_debounce #(
    .STABLE_CYCLES (2),
    .CNT_W         (2),
    .RESET_VAL     (1'b0)
  ) u_dut_b (
    .clk     (clk),
    .clear_n (clear_n),
    .dbus    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_a.rise) rise_a++;
    if (if_a.fall) fall_a++;
    if (if_b.rise) rise_b++;
    if (if_b.fall) fall_b++;
  end

  function automatic logic [3:0] outs_a();
    return {if_a.d_out, if_a.rise, if_a.fall, if_a.busy};
  endfunction

  function automatic logic [3:0] outs_b();
    return {if_b.d_out, if_b.rise, if_b.fall, if_b.busy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got d/r/f/b=%b expected %b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got count %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input string n, input bit c, input bit r, input int e,
                         input logic [3:0] x);
    vec_t v;
    v.name  = n;
    v.clr   = c;
    v.raw   = r;
    v.edges = e;
    v.exp   = x;
    vecs.push_back(v);
  endtask

  initial begin
    int rise0;
    int fall0;
    vectors     = 0;
    miscompares = 0;
    rise_a = 0; fall_a = 0; rise_b = 0; fall_b = 0;
    clear_n     = 1'b0;
    if_a.raw_in = 1'b1;
    if_b.raw_in = 1'b0;

    // Reset, release with raw high, clean fall, short glitch.
    add_vec("rst_hold",     1'b0, 1'b1,  3, 4'b0000);
    add_vec("rel_sync",     1'b1, 1'b1,  2, 4'b0000);
    add_vec("rel_check",    1'b1, 1'b1,  1, 4'b0001);
    add_vec("rel_count",    1'b1, 1'b1, 15, 4'b0001);
    add_vec("rel_commit",   1'b1, 1'b1,  1, 4'b1100);
    add_vec("rel_after",    1'b1, 1'b1,  1, 4'b1000);
    add_vec("hi_steady",    1'b1, 1'b1,  5, 4'b1000);
    add_vec("fall_sync",    1'b1, 1'b0,  2, 4'b1000);
    add_vec("fall_check",   1'b1, 1'b0,  1, 4'b1001);
    add_vec("fall_count",   1'b1, 1'b0, 15, 4'b1001);
    add_vec("fall_commit",  1'b1, 1'b0,  1, 4'b0010);
    add_vec("fall_after",   1'b1, 1'b0,  1, 4'b0000);
    add_vec("glitch_chk",   1'b1, 1'b1,  3, 4'b0001);
    add_vec("glitch_cnt",   1'b1, 1'b1,  7, 4'b0001);
    add_vec("glitch_tail",  1'b1, 1'b0,  2, 4'b0001);
    add_vec("glitch_abort", 1'b1, 1'b0,  1, 4'b0000);
    add_vec("glitch_idle",  1'b1, 1'b0, 20, 4'b0000);

    @(negedge clk);
    #1;
    foreach (vecs[i]) begin
      clear_n     = vecs[i].clr;
      if_a.raw_in = vecs[i].raw;
      tick(vecs[i].edges);
      check(vecs[i].name, outs_a(), vecs[i].exp);
    end
    check_cnt("table_rise_count", rise_a, 1);
    check_cnt("table_fall_count", fall_a, 1);

    // Bounce every 3 cycles for 30 cycles, then settle high.
    rise0 = rise_a;
    fall0 = fall_a;
    for (int s = 0; s < 10; s++) begin
      if_a.raw_in = (s % 2 == 0);
      tick(3);
    end
    check("bounce_end", outs_a(), 4'b0000);
    check_cnt("bounce_no_rise", rise_a, rise0);
    if_a.raw_in = 1'b1;
    tick(18);
    check("settle_18", outs_a(), 4'b0001);
    tick(1);
    check("settle_19", outs_a(), 4'b1100);
    tick(1);
    check("settle_20", outs_a(), 4'b1000);
    check_cnt("settle_rise_once", rise_a, rise0 + 1);
    check_cnt("settle_no_fall", fall_a, fall0);

    // Reset in the middle of a qualification with raw held high.
    clear_n = 1'b0;
    tick(2);
    check("mid_pre_rst", outs_a(), 4'b0000);
    rise0 = rise_a;
    fall0 = fall_a;
    clear_n = 1'b1;
    tick(10);
    check("mid_qualifying", outs_a(), 4'b0001);
    clear_n = 1'b0;
    #1;
    check("mid_async_rst", outs_a(), 4'b0000);
    tick(1);
    check("mid_rst_held", outs_a(), 4'b0000);
    clear_n = 1'b1;
    tick(18);
    check("mid_rel_18", outs_a(), 4'b0001);
    tick(1);
    check("mid_rel_19", outs_a(), 4'b1100);
    tick(1);
    check("mid_rel_20", outs_a(), 4'b1000);
    check_cnt("mid_rise_once", rise_a, rise0 + 1);
    check_cnt("mid_no_fall", fall_a, fall0);

    // STABLE_CYCLES = 2: clean step commits at E4, 2-cycle glitch is filtered.
    check_cnt("b_idle_no_strobe", rise_b + fall_b, 0);
    if_b.raw_in = 1'b1;
    tick(4);
    check("b_step_e3", outs_b(), 4'b0001);
    tick(1);
    check("b_step_e4", outs_b(), 4'b1100);
    tick(1);
    check("b_step_e5", outs_b(), 4'b1000);
    if_b.raw_in = 1'b0;
    tick(2);
    if_b.raw_in = 1'b1;
    tick(1);
    check("b_glitch_e2", outs_b(), 4'b1001);
    tick(1);
    check("b_glitch_e3", outs_b(), 4'b1001);
    tick(1);
    check("b_glitch_e4", outs_b(), 4'b1000);
    tick(6);
    check("b_glitch_idle", outs_b(), 4'b1000);
    check_cnt("b_rise_count", rise_b, 1);
    check_cnt("b_fall_count", fall_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_input_debounce.md
# d_input_debounce

Input-conditioning stage that sits directly upstream of the team's D flip-flop: takes an asynchronous, possibly bouncing raw level and produces a clean, clock-synchronous level suitable for that flop's `d` input. It has a two-flop synchronizer, a stability counter with a two-state FSM, and registered one-cycle rise/fall strobes. It is meant for switch and button inputs and other slow external levels.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive extra synchronized samples required before the output changes; legal range 2 .. 2^CNT_W.
- `CNT_W`, default 8: width of the stability counter.
- `RESET_VAL`, default 1'b0: value loaded into the synchronizer flops and `d_out` on reset.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `clear_n`  input  1: asynchronous, active-low reset; asserts immediately, releases on the next rising `clk` edge.
- `raw_in`  input  1: asynchronous raw level; no timing relation to `clk`.
- `d_out`  output  1: debounced, synchronized level; drives a downstream flop's `d`.
- `rise`  output  1: one-cycle strobe when `d_out` goes 0->1.
- `fall`  output  1: one-cycle strobe when `d_out` goes 1->0.
- `busy`  output  1: high while a candidate change is being qualified (FSM in CHECK).

## Operation
- Synchronizer: `sync1 <= raw_in`, `sync2 <= sync1`. Only `sync2` is used downstream. `raw_in` is never used combinationally.
- FSM states are STABLE and CHECK. The counter `cnt` is CNT_W bits wide.
- STABLE:
  - If `sync2 != d_out`, go to CHECK with `cnt <= 0`.
  - Otherwise stay in STABLE with `cnt` held at 0.
- CHECK:
  - If `sync2 == d_out` (bounce returned to the old value), go to STABLE with `cnt <= 0`. No output change and no strobe.
  - Else if `cnt == STABLE_CYCLES-1`, commit: `d_out <= sync2`, assert `rise` or `fall` for that one cycle, go to STABLE with `cnt <= 0`.
  - Else `cnt <= cnt + 1`.
- `rise`/`fall` are registered and high for exactly one cycle per committed change. They are never both high, and they are 0 on any cycle without a commit.
- `busy` is the registered state decode: `busy = (state == CHECK)`.
- The counter never wraps. It is cleared on every exit from CHECK, and its maximum value is STABLE_CYCLES-1.
- Reset values: `sync1 = sync2 = d_out = RESET_VAL`, `rise = fall = busy = 0`, `cnt = 0`, state STABLE. Because the synchronizer resets to `RESET_VAL`, no strobe occurs after reset release unless `raw_in` differs from it.

## Timing
- Latency for a clean step on `raw_in`, set up before edge E0:
  - `sync1` changes at E0 and `sync2` at E1.
  - CHECK is entered at E2.
  - `d_out` and the strobe update at E(STABLE_CYCLES+2). That is the 19th rising edge counting E0 as the 1st, with the default of 16.
- Qualification needs `sync2` at the new value on STABLE_CYCLES+1 consecutive edges (E2 through E(S+2)). A single opposite sample at any of these edges aborts the qualification.
- After an abort, a new qualification may start on the very next edge if `sync2` differs from `d_out` again. There is no dead time.
- If `raw_in` changes again while in CHECK toward the committed-opposite value, the abort rule covers it. Only the value in `sync2` at each edge matters.
- Reset mid-CHECK: all state returns to its reset values immediately, with no strobe. After release, qualification restarts from STABLE.
- Throughput: at most one committed change per STABLE_CYCLES+1 cycles.

## Test plan
- Reset: hold `clear_n = 0` with `raw_in = 1`. Check `d_out = 0`, `rise = fall = busy = 0`. Release and hold `raw_in = 1`: `d_out` goes to 1 at the 19th edge after release, `rise` pulses for exactly 1 cycle, and `fall` stays 0.
- Clean fall: from `d_out = 1`, drive `raw_in = 0` before edge E0. `busy` goes high at E2, and `d_out` goes to 0 with `fall = 1` at E18. Then `busy = 0` and `fall = 0` at E19.
- Short glitch: from `d_out = 0`, pulse `raw_in` high for 10 cycles. `busy` goes high then low, `d_out` stays 0, and no strobe occurs.
- Bounce then settle: toggle `raw_in` 0/1 every 3 cycles for 30 cycles, then hold 1. `d_out` changes exactly once, 19 edges after the final 0->1 transition, with a single `rise` pulse.
- Reset mid-operation: assert `clear_n` for 1 cycle at cycle 8 of a qualification, with `raw_in` held 1 throughout. Outputs go to reset values with no strobe, and `d_out` rises 19 edges after release.
- Parameter corner: use `STABLE_CYCLES = 2` and a clean step. `d_out` changes at E4, and a 2-cycle glitch does not propagate.
